// File: rtl/servo_pkg.sv
// Shared definitions for the servo drive and decode paths: state encoding,
// angle range constants and the 90 kHz tick-domain limits.
package servo_pkg;

   // Decoder FSM states
   typedef enum logic [1:0] {
      ARM,
      IDLE,
      HIGH,
      DRAIN
   } dec_state_e;

   localparam int ANGLE_BITS    = 8;
   localparam int ANGLE_MAX     = 180;
   localparam int ANGLE_CENTER  = 90;

   // Tick-domain limits, one tick equals one degree
   localparam int MIN_TICKS     = 40;
   localparam int MAX_TICKS     = 230;
   localparam int ANGLE_OFFSET  = 45;
   localparam int TIMEOUT_TICKS = 3600;

   localparam int WIDTH_BITS    = 9;
   localparam int TIMEOUT_BITS  = 12;

   // Converts a measured pulse width to an angle code, clamped to 0..ANGLE_MAX.
   // The subtraction is signed so widths below the offset land on zero.
   function automatic logic [ANGLE_BITS-1:0] width_to_angle(input logic [WIDTH_BITS-1:0] width);
      logic signed [9:0] diff;
      logic [ANGLE_BITS-1:0] result;
      diff = $signed({1'b0, width}) - $signed(10'(ANGLE_OFFSET));
      if (diff < 10'sd0) begin
         result = '0;
      end else if (diff > $signed(10'(ANGLE_MAX))) begin
         result = ANGLE_BITS'(ANGLE_MAX);
      end else begin
         result = diff[ANGLE_BITS-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Signal bundle between the PWM decoder and its surroundings: tick and raw
// PWM in, decoded angle with its strobes and the loss-of-signal level out.
interface servo_pwm_decoder_if;
   import servo_pkg::*;

   logic                  tick_90khz;
   logic                  pwm_in;
   logic [ANGLE_BITS-1:0] angle;
   logic                  angle_valid;
   logic                  err_width;
   logic                  signal_lost;

   modport master (
      output tick_90khz,
      output pwm_in,
      input  angle,
      input  angle_valid,
      input  err_width,
      input  signal_lost
   );

   modport slave (
      input  tick_90khz,
      input  pwm_in,
      output angle,
      output angle_valid,
      output err_width,
      output signal_lost
   );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input with registered rise/fall
// strobes. The strobes rise in the same cycle the synchronized level changes.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic level_q;
   logic rise_q;
   logic fall_q;

   // Synchronizer chain and edge strobes, all cleared low by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q  <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         meta_q  <= async_i;
         level_q <= meta_q;
         rise_q  <= meta_q & ~level_q;
         fall_q  <= ~meta_q & level_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures the high time of a hobby-servo PWM signal in 90 kHz ticks and
// converts it to an angle code, rejecting malformed pulses and flagging
// loss of signal when no accepted pulse arrives for two frames.
module servo_pwm_decoder
   import servo_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   servo_pwm_decoder_if.slave   bus
);

   logic                    pwm_level;
   logic                    pwm_rise;
   logic                    pwm_fall;

   dec_state_e              state_q;
   logic [WIDTH_BITS-1:0]   width_q;
   logic [TIMEOUT_BITS-1:0] timeout_q;
   logic [ANGLE_BITS-1:0]   angle_q;
   logic                    angle_valid_q;
   logic                    err_width_q;
   logic                    signal_lost_q;

   logic [WIDTH_BITS-1:0]   width_inc;
   logic [TIMEOUT_BITS-1:0] timeout_inc;

   sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.pwm_in),
      .level_o (pwm_level),
      .rise_o  (pwm_rise),
      .fall_o  (pwm_fall)
   );

   // Candidate counter values: width +1, timeout +1 per tick saturating at all-ones
   always_comb begin
      width_inc   = width_q + WIDTH_BITS'(1);
      timeout_inc = timeout_q;
      if (bus.tick_90khz && (timeout_q != '1)) begin
         timeout_inc = timeout_q + TIMEOUT_BITS'(1);
      end
   end

   // Pulse measurement FSM with registered outputs and the loss-of-signal timer.
   // In ARM the width counter doubles as a settle counter so the synchronizer
   // has sampled the real input before its level is trusted as low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ARM;
         width_q       <= '0;
         timeout_q     <= '0;
         angle_q       <= ANGLE_BITS'(ANGLE_CENTER);
         angle_valid_q <= 1'b0;
         err_width_q   <= 1'b0;
         signal_lost_q <= 1'b1;
      end else begin
         angle_valid_q <= 1'b0;
         err_width_q   <= 1'b0;
         timeout_q     <= timeout_inc;
         if (timeout_inc >= TIMEOUT_BITS'(TIMEOUT_TICKS)) begin
            signal_lost_q <= 1'b1;
         end

         case (state_q)
            ARM: begin
               if (width_q < WIDTH_BITS'(2)) begin
                  width_q <= width_inc;
               end else if (!pwm_level) begin
                  width_q <= '0;
                  state_q <= IDLE;
               end
            end

            IDLE: begin
               if (pwm_rise) begin
                  width_q <= '0;
                  state_q <= HIGH;
               end
            end

            HIGH: begin
               if (pwm_fall) begin
                  state_q <= IDLE;
                  if (width_q < WIDTH_BITS'(MIN_TICKS)) begin
                     err_width_q <= 1'b1;
                  end else begin
                     angle_q       <= width_to_angle(width_q);
                     angle_valid_q <= 1'b1;
                     timeout_q     <= '0;
                     signal_lost_q <= 1'b0;
                  end
               end else if (bus.tick_90khz) begin
                  width_q <= width_inc;
                  if (width_inc > WIDTH_BITS'(MAX_TICKS)) begin
                     err_width_q <= 1'b1;
                     state_q     <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (pwm_fall) begin
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= ARM;
            end
         endcase
      end
   end

   assign bus.angle       = angle_q;
   assign bus.angle_valid = angle_valid_q;
   assign bus.err_width   = err_width_q;
   assign bus.signal_lost = signal_lost_q;

endmodule
